// File: rtl/cpu_run_sequencer_if.sv
// rtl/cpu_run_sequencer_if.sv - CPU run sequencer control, memory-read and dump-stream bundle
interface cpu_run_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              start;
  logic              end_program;
  logic              unit_rst;
  logic              ins_en;
  logic              dm_en;
  logic              dm_rd_en;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [31:0]       cycle_count;

  modport master (
    input  start, end_program, dm_rdata, dump_ready,
    output unit_rst, ins_en, dm_en, dm_rd_en, dm_addr,
           dump_valid, dump_addr, dump_data, busy, done, timeout, cycle_count
  );

  modport slave (
    output start, end_program, dm_rdata, dump_ready,
    input  unit_rst, ins_en, dm_en, dm_rd_en, dm_addr,
           dump_valid, dump_addr, dump_data, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/cpu_run_sequencer.sv
// rtl/cpu_run_sequencer.sv - reset/run/drain/dump sequencer around the pipelined CPU
// Optional RUN-cycle watchdog enabled by defining CPU_RUN_WATCHDOG_EN.
module cpu_run_sequencer #(
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 5,
  parameter int DM_WORDS     = 512,
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int MAX_CYCLES   = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_run_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
  } state_t;

  localparam int CNT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DM_WORDS - 1);

  if (RST_CYCLES < 1 || DRAIN_CYCLES < 1 || DM_WORDS < 1 ||
      DM_WORDS > (1 << ADDR_W) || MAX_CYCLES < 1) begin : g_bad_param
    $error("cpu_run_sequencer: parameter out of range");
  end

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              unit_rst_q;
  logic              ins_en_q;
  logic              dm_en_q;
  logic              dm_rd_en_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic              dump_valid_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [31:0]       cycle_count_q;
  logic [31:0]       cycle_count_d;
  logic              wd_hit_d;

  always_comb begin
    cycle_count_d = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
  end

`ifdef CPU_RUN_WATCHDOG_EN
  assign wd_hit_d = (cycle_count_d >= 32'(MAX_CYCLES));
`else
  assign wd_hit_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      unit_rst_q    <= 1'b1;
      ins_en_q      <= 1'b0;
      dm_en_q       <= 1'b0;
      dm_rd_en_q    <= 1'b0;
      dm_addr_q     <= '0;
      dump_valid_q  <= 1'b0;
      dump_addr_q   <= '0;
      dump_data_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        // DONE keeps the CPU out of reset so its state survives until the next start.
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q       <= S_RESET;
            cnt_q         <= RST_LOAD;
            unit_rst_q    <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            dm_addr_q     <= '0;
          end
        end
        S_RESET: begin
          if (cnt_q == '0) begin
            state_q    <= S_RUN;
            unit_rst_q <= 1'b0;
            ins_en_q   <= 1'b1;
            dm_en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RUN: begin
          cycle_count_q <= cycle_count_d;
          if (bus.end_program || wd_hit_d) begin
            state_q  <= S_DRAIN;
            cnt_q    <= DRAIN_LOAD;
            ins_en_q <= 1'b0;
            if (!bus.end_program) timeout_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_q    <= S_DUMP_RD;
            dm_rd_en_q <= 1'b1;
            dm_addr_q  <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DUMP_RD: begin
          dm_rd_en_q <= 1'b0;
          state_q    <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          dump_data_q  <= bus.dm_rdata;
          dump_addr_q  <= dm_addr_q;
          dump_valid_q <= 1'b1;
          state_q      <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (bus.dump_ready) begin
            dump_valid_q <= 1'b0;
            if (dm_addr_q == LAST_ADDR) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              dm_en_q <= 1'b0;
            end else begin
              dm_addr_q  <= dm_addr_q + ADDR_W'(1);
              dm_rd_en_q <= 1'b1;
              state_q    <= S_DUMP_RD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.unit_rst    = unit_rst_q;
  assign bus.ins_en      = ins_en_q;
  assign bus.dm_en       = dm_en_q;
  assign bus.dm_rd_en    = dm_rd_en_q;
  assign bus.dm_addr     = dm_addr_q;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_addr   = dump_addr_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb/tb_cpu_run_sequencer.sv - scoreboard bench for cpu_run_sequencer
module tb_cpu_run_sequencer;
  localparam int RST_CYCLES   = 4;
  localparam int DRAIN_CYCLES = 5;
  localparam int DM_WORDS     = 4;
  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 32;
  localparam int MAX_CYCLES   = 50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  cpu_run_sequencer #(
    .RST_CYCLES(RST_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .DM_WORDS(DM_WORDS),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  word_t sb_q[$];
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Read data is only meaningful the cycle after a strobe; poison it otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.dm_rdata <= bus.dm_rd_en ? mem[bus.dm_addr] : 32'hBAD0_BAD0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and polices hold behaviour.
  logic              prev_valid = 1'b0;
  logic              prev_hs    = 1'b0;
  logic              prev_rst   = 1'b1;
  logic [ADDR_W-1:0] prev_addr  = '0;
  logic [DATA_W-1:0] prev_data  = '0;
  int  last_hs     = -1;
  int  hs_cnt      = 0;
  bit  chk_spacing = 1'b0;
  word_t exp_w;

  always @(negedge clk) begin
    if (!prev_rst && prev_valid && !prev_hs) begin
      check("hold_valid", 32'(bus.dump_valid), 32'd1);
      check("hold_addr", 32'(bus.dump_addr), 32'(prev_addr));
      check("hold_data", bus.dump_data, prev_data);
    end
    if (bus.dump_valid === 1'b1) check("no_rd_while_valid", 32'(bus.dm_rd_en), 32'd0);
    if (bus.dump_valid === 1'b1 && bus.dump_ready && !rst) begin
      hs_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_word", 32'(bus.dump_addr), 32'hFFFF_FFFF);
      end else begin
        exp_w = sb_q.pop_front();
        check("dump_addr", 32'(bus.dump_addr), 32'(exp_w.addr));
        check("dump_data", bus.dump_data, exp_w.data);
      end
      if (chk_spacing && last_hs >= 0) check("hs_spacing", 32'(cyc - last_hs), 32'd3);
      last_hs = cyc;
    end
    prev_valid = (bus.dump_valid === 1'b1);
    prev_hs    = (bus.dump_valid === 1'b1) && bus.dump_ready && !rst;
    prev_rst   = rst;
    prev_addr  = bus.dump_addr;
    prev_data  = bus.dump_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    mem[0] = d0; mem[1] = d1; mem[2] = d2; mem[3] = d3;
    sb_q.push_back('{addr: 9'd0, data: d0});
    sb_q.push_back('{addr: 9'd1, data: d1});
    sb_q.push_back('{addr: 9'd2, data: d2});
    sb_q.push_back('{addr: 9'd3, data: d3});
  endtask

  task automatic wait_ins_en();
    int n = 0;
    while (!bus.ins_en && n < 50) begin tick(); n++; end
    check("reach_run", 32'(bus.ins_en), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 200) begin tick(); n++; end
    check("reach_done", 32'(bus.done), 32'd1);
  endtask

  task automatic wait_word(input int a);
    int n = 0;
    while (!(bus.dump_valid && 32'(bus.dump_addr) == a) && n < 100) begin tick(); n++; end
    check("reach_word", 32'(bus.dump_valid && 32'(bus.dump_addr) == a), 32'd1);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int d;
    bus.start = 1'b0;
    bus.end_program = 1'b0;
    bus.dump_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    check("rst_unit_rst", 32'(bus.unit_rst), 32'd1);
    check("rst_ins_en", 32'(bus.ins_en), 32'd0);
    check("rst_dm_en", 32'(bus.dm_en), 32'd0);
    check("rst_dm_rd_en", 32'(bus.dm_rd_en), 32'd0);
    check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_cycle_count", bus.cycle_count, 32'd0);
    check("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    check("rst_dump_addr", 32'(bus.dump_addr), 32'd0);
    check("rst_dump_data", bus.dump_data, 32'd0);
    rst = 1'b0;
    bus.end_program = 1'b1;
    tick();
    bus.end_program = 1'b0;
    check("idle_ignores_endprog", 32'(bus.busy), 32'd0);

    // Run 1: normal run, end_program in RUN cycle 20, ready tied high.
    push_words(32'h11, 32'h22, 32'h33, 32'h44);
    chk_spacing = 1'b1; last_hs = -1; hs_cnt = 0;
    start_pulse();
    check("r1_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.unit_rst && n < 20) begin bus.end_program = 1'b1; tick(); n++; end
    bus.end_program = 1'b0;
    check("r1_rst_cycles", 32'(n), 32'd4);
    check("r1_ins_en", 32'(bus.ins_en), 32'd1);
    check("r1_dm_en", 32'(bus.dm_en), 32'd1);
    check("r1_count_start", bus.cycle_count, 32'd0);
    start_pulse();
    check("r1_start_in_run", 32'(bus.ins_en), 32'd1);
    check("r1_count_1", bus.cycle_count, 32'd1);
    repeat (18) tick();
    bus.end_program = 1'b1;
    tick();
    bus.end_program = 1'b0;
    check("r1_cycle_count", bus.cycle_count, 32'd20);
    check("r1_drain_ins_en", 32'(bus.ins_en), 32'd0);
    check("r1_drain_dm_en", 32'(bus.dm_en), 32'd1);
    check("r1_drain_unit_rst", 32'(bus.unit_rst), 32'd0);
    d = 0;
    while (!bus.dm_rd_en && d < 20) begin bus.start = (d == 1); tick(); d++; end
    bus.start = 1'b0;
    check("r1_drain_cycles", 32'(d), 32'd5);
    check("r1_first_addr", 32'(bus.dm_addr), 32'd0);
    check("r1_busy_after_drain_start", 32'(bus.busy), 32'd1);
    wait_done();
    check("r1_busy_done", 32'(bus.busy), 32'd0);
    check("r1_done_ins_en", 32'(bus.ins_en), 32'd0);
    check("r1_done_dm_en", 32'(bus.dm_en), 32'd0);
    check("r1_done_unit_rst", 32'(bus.unit_rst), 32'd0);
    check("r1_done_count", bus.cycle_count, 32'd20);
    check("r1_hs_cnt", 32'(hs_cnt), 32'd4);
    check("r1_sb_empty", 32'(sb_q.size()), 32'd0);
    chk_spacing = 1'b0;

    // Run 2: start from DONE, backpressure 7 cycles on word 2.
    push_words(32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678);
    hs_cnt = 0;
    start_pulse();
    check("r2_done_cleared", 32'(bus.done), 32'd0);
    check("r2_unit_rst", 32'(bus.unit_rst), 32'd1);
    check("r2_count_cleared", bus.cycle_count, 32'd0);
    wait_ins_en();
    bus.end_program = 1'b1;
    tick();
    bus.end_program = 1'b0;
    check("r2_cycle_count", bus.cycle_count, 32'd1);
    wait_word(1);
    tick();
    bus.dump_ready = 1'b0;
    wait_word(2);
    repeat (7) begin
      check("r2_bp_valid", 32'(bus.dump_valid), 32'd1);
      check("r2_bp_addr", 32'(bus.dump_addr), 32'd2);
      tick();
    end
    check("r2_bp_data", bus.dump_data, 32'hFFFF_FFFF);
    bus.dump_ready = 1'b1;
    wait_done();
    check("r2_hs_cnt", 32'(hs_cnt), 32'd4);
    check("r2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Run 3: reset while word 1 is presented.
    push_words(32'h11, 32'h22, 32'h33, 32'h44);
    start_pulse();
    wait_ins_en();
    bus.end_program = 1'b1;
    tick();
    bus.end_program = 1'b0;
    wait_word(0);
    tick();
    bus.dump_ready = 1'b0;
    wait_word(1);
    rst = 1'b1;
    tick();
    check("r3_dump_valid", 32'(bus.dump_valid), 32'd0);
    check("r3_unit_rst", 32'(bus.unit_rst), 32'd1);
    check("r3_cycle_count", bus.cycle_count, 32'd0);
    check("r3_busy", 32'(bus.busy), 32'd0);
    check("r3_dm_en", 32'(bus.dm_en), 32'd0);
    check("r3_no_partial_hs", 32'(sb_q.size()), 32'd3);
    rst = 1'b0;
    sb_q.delete();
    bus.dump_ready = 1'b1;
    tick();

    // Run 4: fresh run after mid-dump reset.
    push_words(32'h5A5A_0001, 32'hA5A5_0002, 32'h0F0F_0003, 32'hF0F0_0004);
    hs_cnt = 0;
    start_pulse();
    n = 0;
    while (bus.unit_rst && n < 20) begin tick(); n++; end
    check("r4_rst_cycles", 32'(n), 32'd4);
    bus.end_program = 1'b1;
    tick();
    bus.end_program = 1'b0;
    check("r4_cycle_count", bus.cycle_count, 32'd1);
    wait_done();
    check("r4_hs_cnt", 32'(hs_cnt), 32'd4);
    check("r4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Run 5: RUN-cycle limit behaviour.
    push_words(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
    hs_cnt = 0;
    start_pulse();
`ifdef CPU_RUN_WATCHDOG_EN
    n = 0;
    while (!bus.timeout && n < 200) begin tick(); n++; end
    check("r5_timeout", 32'(bus.timeout), 32'd1);
    check("r5_count_at_limit", bus.cycle_count, 32'd50);
    check("r5_ins_en", 32'(bus.ins_en), 32'd0);
    wait_done();
    check("r5_timeout_sticky", 32'(bus.timeout), 32'd1);
`else
    wait_ins_en();
    repeat (200) tick();
    check("r5_still_run", 32'(bus.ins_en), 32'd1);
    check("r5_busy", 32'(bus.busy), 32'd1);
    check("r5_timeout", 32'(bus.timeout), 32'd0);
    check("r5_count", bus.cycle_count, 32'd200);
    bus.end_program = 1'b1;
    tick();
    bus.end_program = 1'b0;
    wait_done();
    check("r5_timeout_done", 32'(bus.timeout), 32'd0);
`endif
    check("r5_hs_cnt", 32'(hs_cnt), 32'd4);
    check("r5_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
Top-level run controller for the pipelined CPU. It performs the following sequence:
- Holds all CPU units in reset for a fixed number of cycles.
- Enables instruction and data memory and runs the program.
- Detects end_program and drains the pipeline.
- Walks data memory word by word, streaming each word to a dump sink over a valid/ready handshake.

It replaces hand-driven reset, enable and printmem sequencing around the CPU, and provides a cycle count and completion status.

Parameters:
RST_CYCLES, 4, cycles unit_rst is held high after start (min 1)
DRAIN_CYCLES, 5, cycles after end_program before the dump begins (pipeline depth)
DM_WORDS, 512, number of data-memory words to dump (min 1)
ADDR_W, 9, data-memory word address width
DATA_W, 32, data-memory word width
MAX_CYCLES, 100000, RUN-cycle limit (used only with the optional feature)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset of this block
start  in  1  begin a run; sampled only in IDLE or DONE
end_program  in  1  CPU end-of-program flag
unit_rst  out  1  common reset to register file, control, ALU, pipeline regs, forwarding unit, memories
ins_en  out  1  instruction memory enable
dm_en  out  1  data memory enable
dm_rd_en  out  1  data memory read strobe (dump phase)
dm_addr  out  ADDR_W  data memory read address
dm_rdata  in  DATA_W  read data, valid exactly 1 cycle after dm_rd_en
dump_valid  out  1  dump word available
dump_ready  in  1  sink accepts dump word
dump_addr  out  ADDR_W  address of current dump word
dump_data  out  DATA_W  current dump word
busy  out  1  high in RESET, RUN, DRAIN, DUMP_RD, DUMP_WAIT, DUMP_OUT
done  out  1  dump complete; held until next start
timeout  out  1  RUN ended by cycle limit (sticky until next start)
cycle_count  out  32  cycles spent in RUN; saturates at 0xFFFFFFFF

Behaviour:
- rst (any state, any time) -> next edge:
  - state IDLE, unit_rst=1.
  - ins_en, dm_en, dm_rd_en, dump_valid, busy, done, timeout = 0.
  - dm_addr, dump_addr, dump_data, cycle_count = 0.
- A reset mid-dump drops dump_valid immediately; no partial handshake completes.
- All outputs are registered.
- IDLE: unit_rst=1. start=1 -> RESET. The cycle counter, done, timeout and dm_addr are cleared on this transition.
- RESET: unit_rst=1 for exactly RST_CYCLES cycles, counted by an internal down-counter, then -> RUN. end_program is ignored in this state.
- RUN:
  - unit_rst=0, ins_en=1, dm_en=1.
  - cycle_count increments every cycle, saturating.
  - end_program=1 sampled -> DRAIN. The cycle in which end_program is seen is counted.
- DRAIN: ins_en=0, dm_en=1, unit_rst=0. Lasts DRAIN_CYCLES cycles, then -> DUMP_RD with dm_addr=0.
- DUMP_RD: dm_rd_en=1 for one cycle -> DUMP_WAIT.
- DUMP_WAIT: dm_rd_en=0; capture dm_rdata into dump_data, dump_addr=dm_addr -> DUMP_OUT.
- DUMP_OUT:
  - dump_valid=1; dump_data and dump_addr held stable until dump_valid & dump_ready.
  - On handshake: dump_valid=0 on the next edge.
  - If dm_addr==DM_WORDS-1 -> DONE; else dm_addr+1 -> DUMP_RD.
  - dump_ready already high on entry completes in that cycle.
  - Maximum throughput is one word per 3 cycles.
- DONE: done=1, busy=0, ins_en=0, dm_en=0, unit_rst=0 so the CPU state is preserved. start=1 -> RESET (new run).
- start while busy is ignored. end_program outside RUN is ignored.
- dm_addr never exceeds DM_WORDS-1. No wrap occurs. DM_WORDS=1 dumps a single word.

Optional Feature:
CPU_RUN_WATCHDOG_EN
- Defined: in RUN, when cycle_count reaches MAX_CYCLES without end_program:
  - timeout=1 (sticky), then -> DRAIN and the dump proceeds normally.
  - end_program in the same cycle takes priority; timeout stays 0.
- Undefined: no limit check; timeout is tied to 0; RUN waits indefinitely.

Test Plan:
- Normal run, RST_CYCLES=4, DRAIN_CYCLES=5: start pulse; end_program rises 20 cycles into RUN -> unit_rst high exactly 4 cycles; cycle_count=20; ins_en falls and 5 drain cycles follow; first dm_rd_en with dm_addr=0.
- Dump with DM_WORDS=4, dump_ready tied 1, memory preloaded 0x11,0x22,0x33,0x44 -> four handshakes, addr 0..3 in order with matching data, 3 cycles apart; done=1, busy=0 afterwards.
- Backpressure: dump_ready low 7 cycles on word 2 -> dump_valid, dump_addr=2 and dump_data held stable for all 7 cycles; no extra dm_rd_en issued.
- rst asserted while in DUMP_OUT on word 1 -> next edge IDLE, dump_valid=0, unit_rst=1, cycle_count=0; a later start produces a full fresh run.
- start pulsed during RUN and DRAIN -> ignored. end_program during RESET -> ignored, RUN still entered. start in DONE -> done clears and new RESET begins.
- With CPU_RUN_WATCHDOG_EN, MAX_CYCLES=50, end_program never set -> timeout=1 at cycle_count=50, dump completes, done=1. Without the macro -> still in RUN after 200 cycles, timeout=0.
